// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, requester ids
// and the round-robin winner selection.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // A lone requester always wins; on a tie the side not served last wins.
  function automatic logic pick_winner(input logic req_if, input logic req_dm,
                                       input logic last);
    if (req_if && req_dm) return ~last;
    else if (req_dm)      return GNT_DM;
    else                  return GNT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multicycle memory between instruction fetch
// (read-only) and data access (read/write); one access every MEM_LAT+2 cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wd,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_mr,
  output logic          mem_mw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    arb_state
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  arb_state_t    state, state_nxt;
  logic [3:0]    cnt;
  logic          grant;
  logic          last_grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wd;
  logic          winner;
  logic          any_req;

  assign any_req = if_req | dm_req;
  assign winner  = pick_winner(if_req, dm_req, last_grant);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request inputs are captured only at selection so the memory sees a stable
  // address/data for the whole access regardless of what the requester does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      grant      <= GNT_IF;
      last_grant <= GNT_IF;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wd     <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            lat_we     <= (winner == GNT_DM) ? dm_we : 1'b0;
            lat_addr   <= (winner == GNT_DM) ? dm_addr : if_addr;
            lat_wd     <= (winner == GNT_DM) ? dm_wd : '0;
            cnt        <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            if (grant == GNT_DM) dm_rdata <= mem_rd;
            else                 if_rdata <= mem_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_mr    = (state == ACCESS) && !lat_we;
  assign mem_mw    = (state == ACCESS) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wd    = lat_wd;
  assign if_ready  = (state == RESP) && (grant == GNT_IF);
  assign dm_ready  = (state == RESP) && (grant == GNT_DM);
  assign arb_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus corner-case
// sequences, with a cycle-stamped scoreboard of expected accesses.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ready_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_mr;
  logic        mem_mw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [1:0]  arb_state;

  logic [31:0] mem [0:15];
  logic        mem_init;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [31:0] last_if;
  logic [31:0] last_dm;
  bit   hold_reqs;
  vec_t vecs [8];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .dm_ready (dm_ready),
    .dm_rdata (dm_rdata),
    .mem_mr   (mem_mr),
    .mem_mw   (mem_mw),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .arb_state(arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: asynchronous read, write on every MW cycle.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[5]  <= 32'h000000AA;
      mem[12] <= 32'h00000033;
      mem[7]  <= 32'h11111111;
    end else if (mem_mw) begin
      mem[mem_addr[3:0]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_addr[3:0]];

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Compares every observable output against the scoreboard head each cycle.
  task automatic checkOutput();
    exp_t h;
    logic exp_mr, exp_mw, exp_rif, exp_rdm;
    logic [1:0] exp_state;
    if (rst) return;
    exp_mr = 1'b0; exp_mw = 1'b0; exp_rif = 1'b0; exp_rdm = 1'b0; exp_state = 2'd0;
    h = '{dm: 1'b0, we: 1'b0, addr: 32'h0, wd: 32'h0, rdata: 32'h0, ready_cyc: -1};
    if (sb.size() > 0) begin
      h = sb[0];
      if (cyc == h.ready_cyc) begin
        exp_state = 2'd2;
        exp_rif   = !h.dm;
        exp_rdm   = h.dm;
      end else if (cyc >= h.ready_cyc - LAT && cyc < h.ready_cyc) begin
        exp_state = 2'd1;
        exp_mr    = !h.we;
        exp_mw    = h.we;
      end
    end
    checkVal("arb_state", 32'(arb_state), 32'(exp_state));
    checkVal("mem_mr", 32'(mem_mr), 32'(exp_mr));
    checkVal("mem_mw", 32'(mem_mw), 32'(exp_mw));
    checkVal("if_ready", 32'(if_ready), 32'(exp_rif));
    checkVal("dm_ready", 32'(dm_ready), 32'(exp_rdm));
    if (exp_mr || exp_mw) begin
      checkVal("mem_addr", mem_addr, h.addr);
      if (h.we) checkVal("mem_wd", mem_wd, h.wd);
    end
    if (exp_rif || exp_rdm) begin
      if (h.dm) begin
        checkVal("dm_rdata", dm_rdata, h.rdata);
        checkVal("if_rdata_held", if_rdata, last_if);
        last_dm = h.rdata;
      end else begin
        checkVal("if_rdata", if_rdata, h.rdata);
        checkVal("dm_rdata_held", dm_rdata, last_dm);
        last_if = h.rdata;
      end
      void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    logic ri, rd;
    @(negedge clk);
    ri = if_ready;
    rd = dm_ready;
    checkOutput();
    @(posedge clk);
    #1;
    if (!hold_reqs) begin
      if (ri) if_req = 1'b0;
      if (rd) dm_req = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic dm, input logic we,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input int offset);
    exp_t e;
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wd = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    e = '{dm: dm, we: we, addr: addr, wd: wd, rdata: rdata, ready_cyc: cyc + offset};
    sb.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    sb.delete();
    last_if = 32'h0;
    last_dm = 32'h0;
    checkVal("rst_state", 32'(arb_state), 32'h0);
    checkVal("rst_mem_mr", 32'(mem_mr), 32'h0);
    checkVal("rst_mem_mw", 32'(mem_mw), 32'h0);
    checkVal("rst_if_ready", 32'(if_ready), 32'h0);
    checkVal("rst_dm_ready", 32'(dm_ready), 32'h0);
    checkVal("rst_mem_addr", mem_addr, 32'h0);
    checkVal("rst_mem_wd", mem_wd, 32'h0);
    checkVal("rst_if_rdata", if_rdata, 32'h0);
    checkVal("rst_dm_rdata", dm_rdata, 32'h0);
  endtask

  initial begin
    vecs[0] = '{dm: 1'b0, we: 1'b0, addr: 32'd5,  wd: 32'h0,        rdata: 32'h000000AA};
    vecs[1] = '{dm: 1'b1, we: 1'b1, addr: 32'd12, wd: 32'h00000055, rdata: 32'h00000000};
    vecs[2] = '{dm: 1'b1, we: 1'b0, addr: 32'd12, wd: 32'h0,        rdata: 32'h00000055};
    vecs[3] = '{dm: 1'b0, we: 1'b0, addr: 32'd12, wd: 32'h0,        rdata: 32'h00000055};
    vecs[4] = '{dm: 1'b1, we: 1'b0, addr: 32'd7,  wd: 32'h0,        rdata: 32'h11111111};
    vecs[5] = '{dm: 1'b1, we: 1'b1, addr: 32'd3,  wd: 32'hDEADBEEF, rdata: 32'h11111111};
    vecs[6] = '{dm: 1'b0, we: 1'b0, addr: 32'd3,  wd: 32'h0,        rdata: 32'hDEADBEEF};
    vecs[7] = '{dm: 1'b1, we: 1'b0, addr: 32'd5,  wd: 32'h0,        rdata: 32'h000000AA};

    hold_reqs = 1'b0;
    mem_init  = 1'b1;
    if_addr = 32'h0; dm_we = 1'b0; dm_addr = 32'h0; dm_wd = 32'h0;
    last_if = 32'h0; last_dm = 32'h0;
    doReset(2);
    mem_init = 1'b0;

    $display("[TB] single-requester vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wd,
                    vecs[i].rdata, LAT + 1);
      waitDrain(20);
    end

    $display("[TB] address change during access");
    applyStimulus(1'b0, 1'b0, 32'd5, 32'h0, 32'h000000AA, LAT + 1);
    tick();
    tick();
    if_addr = 32'd7;
    waitDrain(20);

    $display("[TB] simultaneous requests from reset");
    doReset(1);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 32'h000000AA, LAT + 1);
    applyStimulus(1'b0, 1'b0, 32'd7, 32'h0, 32'h11111111, 2 * LAT + 3);
    waitDrain(40);

    $display("[TB] fairness with both requests held");
    hold_reqs = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd7,  32'h0, 32'h11111111, LAT + 1);
    applyStimulus(1'b0, 1'b0, 32'd12, 32'h0, 32'h00000055, 2 * LAT + 3);
    applyStimulus(1'b1, 1'b0, 32'd7,  32'h0, 32'h11111111, 3 * LAT + 5);
    applyStimulus(1'b0, 1'b0, 32'd12, 32'h0, 32'h00000055, 4 * LAT + 7);
    waitDrain(60);
    hold_reqs = 1'b0;

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b1, 1'b1, 32'd12, 32'h00000077, 32'h0, LAT + 1);
    tick();
    tick();
    doReset(1);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
